// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin lock-until-done arbiter driving the mux select of a two-requester memory port (in: clk, reset, enable_0/1, valid; out: select, grant_0/1, busy, timeout_error, done_count_0/1)
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_0,
    input  logic             enable_1,
    input  logic             valid,
    output logic             select,
    output logic             grant_0,
    output logic             grant_1,
    output logic             busy,
    output logic             timeout_error,
    output logic [CNT_W-1:0] done_count_0,
    output logic [CNT_W-1:0] done_count_1
);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_n;
    logic last_owner, winner, req, own_en, done, abandon, rel;
    logic [TW-1:0] tcnt;
    always_comb begin
        req = enable_0 | enable_1;
        winner = (enable_0 & enable_1) ? ~last_owner : enable_1;
        own_en = select ? enable_1 : enable_0;
        done = (state == WAIT) & valid;
        abandon = (state == WAIT) & ~valid & ~own_en;
        timeout_error = (state == WAIT) & ~valid & own_en & (TIMEOUT_CYCLES != 0) & (tcnt == T_LAST);
        rel = done | abandon | timeout_error;
        state_n = (state == IDLE) ? (req ? WAIT : IDLE) : (rel ? IDLE : WAIT);
    end
    assign busy = grant_0 | grant_1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            select <= 1'b0;
            grant_0 <= 1'b0;
            grant_1 <= 1'b0;
            last_owner <= 1'b1;
            tcnt <= '0;
            done_count_0 <= '0;
            done_count_1 <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                select <= winner;
                grant_0 <= ~winner;
                grant_1 <= winner;
                tcnt <= '0;
            end else if (rel) begin
                grant_0 <= 1'b0;
                grant_1 <= 1'b0;
                last_owner <= select;
            end else if (state == WAIT) begin
                tcnt <= tcnt + 1'b1;
            end
            if (done && !select && !(&done_count_0))
                done_count_0 <= done_count_0 + 1'b1;
            if (done && select && !(&done_count_1))
                done_count_1 <= done_count_1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed table-driven bench for memory_arbiter (TIMEOUT_CYCLES=4, CNT_W=2)
module tb_memory_arbiter;
    logic clk = 1'b0, reset = 1'b1, enable_0 = 1'b0, enable_1 = 1'b0, valid = 1'b0;
    logic select, grant_0, grant_1, busy, timeout_error;
    logic [1:0] done_count_0, done_count_1;
    int passed = 0, total = 0;
    typedef struct {int rst, e0, e1, v, sel, g0, g1, bsy, to, d0, d1;} vec_t;
    vec_t tbl [16];
    memory_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .enable_0(enable_0), .enable_1(enable_1), .valid(valid),
        .select(select), .grant_0(grant_0), .grant_1(grant_1), .busy(busy),
        .timeout_error(timeout_error), .done_count_0(done_count_0), .done_count_1(done_count_1)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask
    task automatic step(input int r, input int a, input int b, input int c);
        reset = r[0];
        enable_0 = a[0];
        enable_1 = b[0];
        valid = c[0];
        @(posedge clk);
        #1;
        chk("one_hot_grant", int'(grant_0 & grant_1), 0);
        chk("busy_eq_grants", int'(busy), int'(grant_0 | grant_1));
    endtask
    task automatic chk_out(input string n, input int sel, input int g0, input int g1, input int bsy, input int to, input int d0, input int d1);
        chk({n, ".select"}, int'(select), sel);
        chk({n, ".grant_0"}, int'(grant_0), g0);
        chk({n, ".grant_1"}, int'(grant_1), g1);
        chk({n, ".busy"}, int'(busy), bsy);
        chk({n, ".timeout_error"}, int'(timeout_error), to);
        chk({n, ".done_count_0"}, int'(done_count_0), d0);
        chk({n, ".done_count_1"}, int'(done_count_1), d1);
    endtask
    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
        tbl[5]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1};
        tbl[7]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 2, 1};
        tbl[8]  = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 2, 1};
        tbl[9]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 2, 2};
        tbl[10] = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 2, 2};
        tbl[11] = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 2, 2};
        tbl[12] = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 2, 2};
        tbl[13] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 2, 2};
        tbl[14] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 2, 2};
        tbl[15] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 2, 2};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].e0, tbl[i].e1, tbl[i].v);
            chk_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].g0, tbl[i].g1, tbl[i].bsy, tbl[i].to, tbl[i].d0, tbl[i].d1);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("timeout_armed", int'(timeout_error), 1);
        valid = 1'b1;
        #1;
        chk("coincide_no_error", int'(timeout_error), 0);
        step(0, 0, 1, 1);
        chk_out("coincide_done", 1, 0, 0, 0, 0, 2, 3);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            chk_out($sformatf("sat_grant%0d", k), 0, 1, 0, 1, 0, k == 0 ? 2 : 3, 3);
            step(0, 1, 0, 1);
            chk_out($sformatf("sat_done%0d", k), 0, 0, 0, 0, 0, 3, 3);
        end
        step(0, 1, 0, 0);
        chk_out("abandon_grant", 0, 1, 0, 1, 0, 3, 3);
        step(0, 0, 1, 0);
        chk_out("abandon", 0, 0, 0, 0, 0, 3, 3);
        step(0, 0, 1, 0);
        chk_out("pending_r1", 1, 0, 1, 1, 0, 3, 3);
        step(1, 0, 1, 0);
        chk_out("reset_in_wait", 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0);
        chk_out("post_reset_tie", 0, 1, 0, 1, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Round-robin arbiter that drives the select input of the two-requester memory mux. It shares one memory port between requester 0 and requester 1.
- A grant stays locked from the winning request until the memory returns valid, the owner abandons, or a timeout expires. The select line therefore never switches mid-transaction.
- Sits beside the mux: observes enable_0/enable_1 and the memory-side valid; outputs select plus per-requester status.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in WAIT without valid before forced release; 0 disables the timeout.
- CNT_W, 16: width of the per-requester completion counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_0  input  1  request from requester 0; held high until its valid.
- enable_1  input  1  request from requester 1; held high until its valid.
- valid  input  1  memory-side completion pulse (pre-mux).
- select  output  1  mux select: 0 = requester 0, 1 = requester 1; registered.
- grant_0  output  1  requester 0 owns the port; registered.
- grant_1  output  1  requester 1 owns the port; registered.
- busy  output  1  high in WAIT state.
- timeout_error  output  1  one-cycle pulse on forced release.
- done_count_0  output  CNT_W  completed (valid-terminated) transactions for requester 0; saturating.
- done_count_1  output  CNT_W  same for requester 1.

Behaviour:
- Reset values:
  - select=0, grant_0=0, grant_1=0, busy=0, timeout_error=0.
  - done_count_0=0, done_count_1=0.
  - state=IDLE, last_owner=1, so requester 0 wins the first tie.
  - Reset mid-transaction drops all grants at the next edge; no completion is counted.
- State IDLE:
  - No requests: stay in IDLE.
  - One request: that requester wins.
  - Both requesting: the winner is the requester that is not last_owner.
  - On a win, at the next edge: select<=winner, grant_winner<=1, busy<=1, timeout counter<=0, go to WAIT.
  - Latency: enable seen in cycle n gives select/grant valid in cycle n+1.
- State WAIT:
  - select is held constant. Exactly one grant is high.
  - Events are evaluated in this priority order:
    1. valid==1: completion. Increment done_count_select, saturating at all-ones. last_owner<=select. Clear grants and busy. Go to IDLE. select keeps its value.
    2. Owner's enable==0 and valid==0: abandon. last_owner<=select. Clear grants and busy. Go to IDLE. No count, no error.
    3. TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: timeout. timeout_error pulses for 1 cycle. last_owner<=select. Clear grants and busy. Go to IDLE.
    4. Otherwise: counter increments.
  - valid and timeout on the same cycle: completion wins, no error.
  - The non-owner's enable is ignored in WAIT.
- Minimum turnaround is one IDLE cycle between transactions. The maximum back-to-back rate is therefore one grant per 2 cycles plus memory latency.
- valid while in IDLE is ignored: no count, no state change.
- Invariants:
  - grant_0 and grant_1 are never both high.
  - busy == (grant_0 | grant_1).
  - select changes only on the IDLE->WAIT edge.
- Counter widths:
  - Timeout counter width is clog2(TIMEOUT_CYCLES+1).
  - Done counters saturate and do not wrap.

Test Plan:
- Single requester: enable_0=1 at cycle 2, valid at cycle 5 -> grant_0/busy high cycles 3-5, select=0, done_count_0=1 at cycle 6, grant_0=0 at cycle 6.
- Tie after reset: enable_0=enable_1=1 at cycle 1 -> grant_0 at cycle 2. After valid, requester 1 is granted next with select=1. After that valid, requester 0 is granted again (strict alternation over 4 transactions, 2 each).
- Timeout: TIMEOUT_CYCLES=4, enable_1 held, no valid -> grant_1 high 4 cycles, timeout_error single pulse on the 4th, done_count_1 unchanged, busy=0 next cycle.
- Valid coincident with timeout cycle -> done_count increments, timeout_error stays 0.
- Abandon: requester 0 granted, drops enable_0 before valid -> grant_0 clears next edge, no count, no error. A pending enable_1 is granted on the following IDLE cycle.
- Reset in WAIT with enable_1 granted -> all outputs return to reset values next edge. The first post-reset tie grants requester 0. Counter saturation check: preload near max (CNT_W=2) -> count sticks at 3.
